// File: rtl/load_store_unit_if.sv
// Load/store unit bus bundle: pipeline request/response side plus memory side.
// slave = the load/store unit, master = the pipeline and memory driving it.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        rsp_valid;
  logic [31:0] rdata;
  logic        err;
  logic        misalign;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, funct3, addr, wdata, mem_gnt, mem_rvalid, mem_rdata,
    output stall, rsp_valid, rdata, err, misalign,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output req_valid, req_we, funct3, addr, wdata, mem_gnt, mem_rvalid, mem_rdata,
    input  stall, rsp_valid, rdata, err, misalign,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: turns one execute-stage memory instruction into a gnt/rvalid memory access.
// Optional: define LSU_MISALIGN_CHK_EN to reject misaligned H/W accesses with err+misalign.
module load_store_unit #(
  parameter int unsigned MAX_WAIT = 255
) (
  input logic               clk,
  input logic               rst,
  load_store_unit_if.slave  bus
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_WAIT - 1);
  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [2:0]       f3_q;
  logic [1:0]       off_q;
  logic             we_q;
  logic             mem_req_q;
  logic             mem_we_q;
  logic [31:0]      mem_addr_q;
  logic [3:0]       mem_be_q;
  logic [31:0]      mem_wdata_q;
  logic             rsp_valid_q;
  logic             err_q;
  logic             misalign_q;
  logic [31:0]      rdata_q;

  logic        legal_c;
  logic        misal_c;
  logic        last_c;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [31:0] shifted_c;
  logic [31:0] load_c;

  // Request decode: legality, byte enables and replicated store data
  always_comb begin
    legal_c = 1'b0;
    be_c    = 4'b1111;
    wdata_c = bus.wdata;
    case (bus.funct3)
      F_B, F_H, F_W: legal_c = 1'b1;
      F_BU, F_HU:    legal_c = !bus.req_we;
      default:       legal_c = 1'b0;
    endcase
    case (bus.funct3[1:0])
      2'b00: begin
        be_c    = 4'b0001 << bus.addr[1:0];
        wdata_c = {4{bus.wdata[7:0]}};
      end
      2'b01: begin
        be_c    = 4'b0011 << bus.addr[1:0];
        wdata_c = {2{bus.wdata[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = bus.wdata;
      end
    endcase
  end

`ifdef LSU_MISALIGN_CHK_EN
  assign misal_c = (((bus.funct3 == F_H) || (bus.funct3 == F_HU)) && bus.addr[0]) ||
                   ((bus.funct3 == F_W) && (bus.addr[1:0] != 2'b00));
`else
  assign misal_c = 1'b0;
`endif

  // Load data alignment and extension from the latched size/offset
  always_comb begin
    shifted_c = bus.mem_rdata >> {off_q, 3'b000};
    case (f3_q)
      F_B:     load_c = {{24{shifted_c[7]}}, shifted_c[7:0]};
      F_H:     load_c = {{16{shifted_c[15]}}, shifted_c[15:0]};
      F_BU:    load_c = {24'b0, shifted_c[7:0]};
      F_HU:    load_c = {16'b0, shifted_c[15:0]};
      default: load_c = shifted_c;
    endcase
  end

  assign last_c = (wait_cnt == LAST_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      f3_q        <= '0;
      off_q       <= '0;
      we_q        <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
      misalign_q  <= 1'b0;
      rdata_q     <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
      misalign_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            if (!legal_c || misal_c) begin
              state       <= RESP;
              rsp_valid_q <= 1'b1;
              err_q       <= 1'b1;
              misalign_q  <= misal_c && legal_c;
              rdata_q     <= '0;
            end else begin
              state       <= REQ;
              wait_cnt    <= '0;
              f3_q        <= bus.funct3;
              off_q       <= bus.addr[1:0];
              we_q        <= bus.req_we;
              mem_req_q   <= 1'b1;
              mem_we_q    <= bus.req_we;
              mem_addr_q  <= {bus.addr[31:2], 2'b00};
              mem_be_q    <= be_c;
              mem_wdata_q <= wdata_c;
            end
          end
        end
        REQ: begin
          // Completion on the last budget cycle wins over the timeout
          if (bus.mem_gnt && (we_q || bus.mem_rvalid)) begin
            state       <= RESP;
            mem_req_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rdata_q     <= we_q ? 32'h0 : load_c;
          end else if (last_c) begin
            state       <= RESP;
            mem_req_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            err_q       <= 1'b1;
            rdata_q     <= '0;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
            if (bus.mem_gnt) begin
              state     <= WAIT;
              mem_req_q <= 1'b0;
            end
          end
        end
        WAIT: begin
          if (bus.mem_rvalid) begin
            state       <= RESP;
            rsp_valid_q <= 1'b1;
            rdata_q     <= load_c;
          end else if (last_c) begin
            state       <= RESP;
            rsp_valid_q <= 1'b1;
            err_q       <= 1'b1;
            rdata_q     <= '0;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.stall     = ((state == IDLE) && bus.req_valid) || (state == REQ) || (state == WAIT);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rdata     = rdata_q;
  assign bus.err       = err_q;
  assign bus.misalign  = misalign_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule
